// File: rtl/lcd_serial_video_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_video_pkg
// Brief    : Shared timing defaults, polarity encodings and helper functions
//            for the serial-RGB LCD video generator.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_video_pkg;

    localparam int DEF_H_VISIBLE = 320;
    localparam int DEF_H_FRONT   = 20;
    localparam int DEF_H_SYNC    = 30;
    localparam int DEF_H_BACK    = 38;
    localparam int DEF_V_VISIBLE = 240;
    localparam int DEF_V_FRONT   = 4;
    localparam int DEF_V_SYNC    = 3;
    localparam int DEF_V_BACK    = 15;
    localparam int DEF_CHANNELS  = 3;
    localparam int DEF_CH_WIDTH  = 8;
    localparam int DEF_CNT_W     = 10;

    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;

    function automatic int total4(input int a, input int b, input int c, input int d);
        return a + b + c + d;
    endfunction

    // True when a counter of width w can hold 0..total-1.
    function automatic bit fits(input int total, input int w);
        return (total >= 1) && (total <= (1 << w));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_serial_video_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_serial_video_gen_if
// Brief    : Pixel-source and panel-pin bundle of the LCD video generator.
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_serial_video_gen_if #(
    parameter int CHANNELS = 3,
    parameter int CH_WIDTH = 8,
    parameter int CNT_W    = 10
);
    logic                         ch_rev;
    logic [CHANNELS*CH_WIDTH-1:0] rgb_data;
    logic [CH_WIDTH-1:0]          lcd_dat;
    logic                         lcd_hsync;
    logic                         lcd_vsync;
    logic                         lcd_den;
    logic [CNT_W-1:0]             h_pos;
    logic [CNT_W-1:0]             v_pos;
    logic                         line_start;
    logic                         frame_start;

    modport master (
        input  ch_rev, rgb_data,
        output lcd_dat, lcd_hsync, lcd_vsync, lcd_den,
        output h_pos, v_pos, line_start, frame_start
    );

    modport slave (
        output ch_rev, rgb_data,
        input  lcd_dat, lcd_hsync, lcd_vsync, lcd_den,
        input  h_pos, v_pos, line_start, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/lcd_timing_counter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_timing_counter
// Brief    : Sub-cycle/column/line counters, line/frame strobes and
//            visible/sync decode for the LCD video generator.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_timing_counter
    import lcd_video_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  wire logic             clk,
    input  wire logic             reset,
    output logic                  o_latch,
    output logic [CNT_W-1:0]      o_h_pos,
    output logic [CNT_W-1:0]      o_v_pos,
    output logic                  o_visible,
    output logic                  o_hs_act,
    output logic                  o_vs_act,
    output logic                  o_line_start,
    output logic                  o_frame_start
);

    localparam int H_TOTAL = total4(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = total4(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    if (!fits(H_TOTAL, CNT_W) || !fits(V_TOTAL, CNT_W)) begin : g_cnt_w_check
        $error("lcd_timing_counter: H_TOTAL or V_TOTAL exceeds 2**CNT_W");
    end

    if (CHANNELS < 1 || CHANNELS > 4) begin : g_channels_check
        $error("lcd_timing_counter: CHANNELS must be 1..4");
    end

    localparam logic [1:0]       c_CH_LAST = 2'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] c_H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST  = CNT_W'(V_TOTAL - 1);
    // One extra bit so a sync window ending exactly at 2**CNT_W still compares correctly.
    localparam logic [CNT_W:0]   c_H_VIS   = (CNT_W+1)'(H_VISIBLE);
    localparam logic [CNT_W:0]   c_V_VIS   = (CNT_W+1)'(V_VISIBLE);
    localparam logic [CNT_W:0]   c_HS_BEG  = (CNT_W+1)'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W:0]   c_HS_END  = (CNT_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W:0]   c_VS_BEG  = (CNT_W+1)'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W:0]   c_VS_END  = (CNT_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [1:0]       r_ch;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             r_line_start;
    logic             r_frame_start;

    logic             w_latch;
    logic [1:0]       w_ch_next;
    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    logic             w_ls_next;

    assign w_latch = (r_ch == c_CH_LAST);

    always_comb begin
        w_ch_next = r_ch + 2'd1;
        w_h_next  = r_h;
        w_v_next  = r_v;
        if (w_latch) begin
            w_ch_next = 2'd0;
            if (r_h == c_H_LAST) begin
                w_h_next = '0;
                w_v_next = (r_v == c_V_LAST) ? '0 : r_v + 1'b1;
            end else begin
                w_h_next = r_h + 1'b1;
            end
        end
    end

    // Strobes are registered from next-state values so they align with the counters.
    assign w_ls_next = (w_ch_next == 2'd0) && (w_h_next == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch          <= 2'd0;
            r_h           <= '0;
            r_v           <= '0;
            r_line_start  <= 1'b1;
            r_frame_start <= 1'b1;
        end else begin
            r_ch          <= w_ch_next;
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            r_line_start  <= w_ls_next;
            r_frame_start <= w_ls_next && (w_v_next == '0);
        end
    end

    assign o_latch       = w_latch;
    assign o_h_pos       = r_h;
    assign o_v_pos       = r_v;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;
    assign o_visible     = ({1'b0, r_h} < c_H_VIS) && ({1'b0, r_v} < c_V_VIS);
    assign o_hs_act      = ({1'b0, r_h} >= c_HS_BEG) && ({1'b0, r_h} < c_HS_END);
    assign o_vs_act      = ({1'b0, r_v} >= c_VS_BEG) && ({1'b0, r_v} < c_VS_END);

endmodule
`default_nettype wire

// File: rtl/lcd_serial_video_gen.sv
`default_nettype none
// ============================================================================
// Module   : lcd_serial_video_gen
// Brief    : Serial-RGB LCD timing generator and pixel serialiser; sync/den
//            outputs are aligned with channel 0 of the pixel they describe.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_serial_video_gen
    import lcd_video_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int CH_WIDTH  = DEF_CH_WIDTH,
    parameter int CNT_W     = DEF_CNT_W,
    parameter bit HS_POL    = POL_ACTIVE_LOW,
    parameter bit VS_POL    = POL_ACTIVE_LOW,
    parameter bit DE_POL    = POL_ACTIVE_LOW
) (
    input  wire logic              clk,
    input  wire logic              reset,
    lcd_serial_video_gen_if.master bus
);

    localparam int c_W = CHANNELS * CH_WIDTH;

    logic             w_latch;
    logic             w_visible;
    logic             w_hs_act;
    logic             w_vs_act;
    logic [CNT_W-1:0] w_h_pos;
    logic [CNT_W-1:0] w_v_pos;
    logic             w_line_start;
    logic             w_frame_start;
    logic [c_W-1:0]   w_ord;

    logic [CH_WIDTH-1:0] r_dat;
    logic [c_W-1:0]      r_shift;
    logic                r_hs;
    logic                r_vs;
    logic                r_de;

    lcd_timing_counter #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .CHANNELS  (CHANNELS),
        .CNT_W     (CNT_W)
    ) u_timing (
        .clk           (clk),
        .reset         (reset),
        .o_latch       (w_latch),
        .o_h_pos       (w_h_pos),
        .o_v_pos       (w_v_pos),
        .o_visible     (w_visible),
        .o_hs_act      (w_hs_act),
        .o_vs_act      (w_vs_act),
        .o_line_start  (w_line_start),
        .o_frame_start (w_frame_start)
    );

    // Reorder so channel 0 always sits in the MS slice; blanked pixels shift out zeros.
    always_comb begin
        w_ord = '0;
        if (w_visible) begin
            if (bus.ch_rev) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    w_ord[(CHANNELS-1-k)*CH_WIDTH +: CH_WIDTH] = bus.rgb_data[k*CH_WIDTH +: CH_WIDTH];
                end
            end else begin
                w_ord = bus.rgb_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dat   <= '0;
            r_shift <= '0;
            r_hs    <= ~HS_POL;
            r_vs    <= ~VS_POL;
            r_de    <= ~DE_POL;
        end else if (w_latch) begin
            r_dat   <= w_ord[c_W-1 -: CH_WIDTH];
            r_shift <= w_ord << CH_WIDTH;
            r_hs    <= w_hs_act  ? HS_POL : ~HS_POL;
            r_vs    <= w_vs_act  ? VS_POL : ~VS_POL;
            r_de    <= w_visible ? DE_POL : ~DE_POL;
        end else begin
            r_dat   <= r_shift[c_W-1 -: CH_WIDTH];
            r_shift <= r_shift << CH_WIDTH;
        end
    end

    assign bus.lcd_dat     = r_dat;
    assign bus.lcd_hsync   = r_hs;
    assign bus.lcd_vsync   = r_vs;
    assign bus.lcd_den     = r_de;
    assign bus.h_pos       = w_h_pos;
    assign bus.v_pos       = w_v_pos;
    assign bus.line_start  = w_line_start;
    assign bus.frame_start = w_frame_start;

endmodule
`default_nettype wire
